// File: rtl/seq_gen_piso_pkg.sv
// Shared definitions for the seq_gen_piso parallel-to-serial stage.

`ifndef DLY
// Empty by default; lets a simulation flow add an intra-assignment delay if needed.
`define DLY
`endif

package seq_gen_piso_pkg;

   // FSM encoding for the serialiser.
   typedef enum logic {
      PISO_IDLE  = 1'b0,
      PISO_SHIFT = 1'b1
   } piso_state_e;

   // Default word width.
   localparam int unsigned PISO_WIDTH_DEF = 8;

endpackage

// File: rtl/seq_gen_hold_buf.sv
// One-entry holding buffer in front of the serialiser. Takes a word over
// valid/ready and releases it when the serialiser pops it on a load edge.

module seq_gen_hold_buf
   import seq_gen_piso_pkg::*;
#(
   parameter int unsigned WIDTH = PISO_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             pop,
   output logic [WIDTH-1:0] hold,
   output logic             hold_vld
);

   logic             accept;
   logic [WIDTH-1:0] hold_d;
   logic             hold_vld_d;

   // Ready depends only on the registered flag; accept and pop never coincide
   // because pop needs hold_vld=1, which forces ready low.
   always_comb begin
      data_ready = !hold_vld;
      accept     = data_valid && data_ready;
      hold_d     = hold;
      hold_vld_d = hold_vld;
      if (accept) begin
         hold_d     = data_in;
         hold_vld_d = 1'b1;
      end else if (pop) begin
         hold_vld_d = 1'b0;
      end
   end

   // Holding register and its valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold     <= `DLY '0;
         hold_vld <= `DLY 1'b0;
      end else begin
         hold     <= `DLY hold_d;
         hold_vld <= `DLY hold_vld_d;
      end
   end

endmodule

// File: rtl/seq_gen_piso.sv
// Parallel-in/serial-out stage feeding the serial sequence checker. Words are
// buffered one deep so back-to-back words leave as a gapless bit stream; the
// idle fill on dout is 0.

module seq_gen_piso
   import seq_gen_piso_pkg::*;
#(
   parameter int unsigned WIDTH     = PISO_WIDTH_DEF,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             dout,
   output logic             dout_vld,
   output logic             busy
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             vld_q, vld_d;

   logic [WIDTH-1:0] hold;
   logic             hold_vld;
   logic             cnt_last;
   logic             load;
   logic             hold_first;
   logic             sh_next;
   logic [WIDTH-1:0] sh_shifted;

   seq_gen_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .pop        (load),
      .hold       (hold),
      .hold_vld   (hold_vld)
   );

   // Load the held word when idle or on the edge after the last bit went out.
   always_comb begin
      cnt_last = (cnt_q == CNT_LAST);
      load     = hold_vld && ((state_q == PISO_IDLE) || cnt_last);
   end

   // Bit-order selection: the shifter always presents the next bit at a fixed end.
   always_comb begin
      if (LSB_FIRST) begin
         hold_first = hold[0];
         sh_next    = sh_q[1];
         sh_shifted = sh_q >> 1;
      end else begin
         hold_first = hold[WIDTH-1];
         sh_next    = sh_q[WIDTH-2];
         sh_shifted = sh_q << 1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= `DLY PISO_IDLE;
      end else begin
         state_q <= `DLY state_d;
      end
   end

   // FSM next state: a load always (re)enters SHIFT; the last bit without a
   // waiting word falls back to IDLE.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = PISO_SHIFT;
      end else if ((state_q == PISO_SHIFT) && cnt_last) begin
         state_d = PISO_IDLE;
      end
   end

   // FSM outputs.
   always_comb begin
      busy     = (state_q == PISO_SHIFT) || hold_vld;
      dout     = dout_q;
      dout_vld = vld_q;
   end

   // Datapath next state: shifter, bit counter and registered serial output.
   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      vld_d  = vld_q;
      if (load) begin
         sh_d   = hold;
         cnt_d  = '0;
         dout_d = hold_first;
         vld_d  = 1'b1;
      end else if ((state_q == PISO_SHIFT) && !cnt_last) begin
         sh_d   = sh_shifted;
         cnt_d  = cnt_q + CNT_W'(1);
         dout_d = sh_next;
         vld_d  = 1'b1;
      end else begin
         // Word finished with nothing waiting, or idle: drive the 0 fill.
         cnt_d  = '0;
         dout_d = 1'b0;
         vld_d  = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= `DLY '0;
         cnt_q  <= `DLY '0;
         dout_q <= `DLY 1'b0;
         vld_q  <= `DLY 1'b0;
      end else begin
         sh_q   <= `DLY sh_d;
         cnt_q  <= `DLY cnt_d;
         dout_q <= `DLY dout_d;
         vld_q  <= `DLY vld_d;
      end
   end

endmodule

// File: tb/tb_seq_gen_piso.sv
// Bench for seq_gen_piso: MSB-first and LSB-first instances share one stimulus
// stream and are checked against a queue-based word/bit model every cycle.

module tb_seq_gen_piso;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         data_valid;
   logic         rdy_m, dout_m, vld_m, busy_m;
   logic         rdy_l, dout_l, vld_l, busy_l;

   seq_gen_piso #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (rdy_m),
      .dout       (dout_m),
      .dout_vld   (vld_m),
      .busy       (busy_m)
   );

   seq_gen_piso #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (rdy_l),
      .dout       (dout_l),
      .dout_vld   (vld_l),
      .busy       (busy_l)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one held word plus queues of bits still to be sent.
   logic [W-1:0] m_held;
   bit           m_full;
   bit           q_msb[$];
   bit           q_lsb[$];
   bit           m_dout_m, m_dout_l, m_vld, m_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_held = '0;
      m_full = 1'b0;
      q_msb.delete();
      q_lsb.delete();
      m_dout_m = 1'b0;
      m_dout_l = 1'b0;
      m_vld    = 1'b0;
      m_acc    = 1'b0;
   endtask

   // One clock edge of the model, using the inputs present before the edge.
   task automatic model_step();
      m_acc = data_valid && !m_full;
      if (q_msb.size() == 0 && m_full) begin
         for (int i = 0; i < W; i++) begin
            q_msb.push_back(m_held[W-1-i]);
            q_lsb.push_back(m_held[i]);
         end
         m_full = 1'b0;
      end
      if (q_msb.size() > 0) begin
         m_dout_m = q_msb.pop_front();
         m_dout_l = q_lsb.pop_front();
         m_vld    = 1'b1;
      end else begin
         m_dout_m = 1'b0;
         m_dout_l = 1'b0;
         m_vld    = 1'b0;
      end
      if (m_acc) begin
         m_held = data_in;
         m_full = 1'b1;
      end
   endtask

   task automatic check_model();
      chk("model_ready_msb", rdy_m, !m_full);
      chk("model_ready_lsb", rdy_l, !m_full);
      chk("model_dout_msb", dout_m, m_dout_m);
      chk("model_dout_lsb", dout_l, m_dout_l);
      chk("model_vld_msb", vld_m, m_vld);
      chk("model_vld_lsb", vld_l, m_vld);
      chk("model_busy_msb", busy_m, m_vld || m_full);
      chk("model_busy_lsb", busy_l, m_vld || m_full);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] exp_msb;  // bit W-1 is the first serial bit
      logic [W-1:0] exp_lsb;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] b2b;
      logic [W-1:0] bp_words[3];
      logic [W-1:0] starve_w;
      bit           got[$];
      bit           pre_rdy;
      int           wi, nacc;

      vecs[0] = '{word: 8'h98, exp_msb: 8'b1001_1000, exp_lsb: 8'b0001_1001};
      vecs[1] = '{word: 8'h01, exp_msb: 8'b0000_0001, exp_lsb: 8'b1000_0000};
      vecs[2] = '{word: 8'hA5, exp_msb: 8'b1010_0101, exp_lsb: 8'b1010_0101};
      vecs[3] = '{word: 8'h3C, exp_msb: 8'b0011_1100, exp_lsb: 8'b0011_1100};
      vecs[4] = '{word: 8'hC1, exp_msb: 8'b1100_0001, exp_lsb: 8'b1000_0011};
      vecs[5] = '{word: 8'hFF, exp_msb: 8'b1111_1111, exp_lsb: 8'b1111_1111};

      // Reset state.
      rst_n      = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      model_reset();
      #12;
      chk("reset_ready", rdy_m, 1);
      chk("reset_dout", dout_m, 0);
      chk("reset_vld", vld_m, 0);
      chk("reset_busy", busy_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single words on an idle block, both bit orders.
      for (int v = 0; v < 6; v++) begin
         data_valid = 1'b1;
         data_in    = vecs[v].word;
         tick();
         data_valid = 1'b0;
         for (int i = 0; i < W; i++) begin
            tick();
            chk("vec_bit_msb", dout_m, vecs[v].exp_msb[W-1-i]);
            chk("vec_bit_lsb", dout_l, vecs[v].exp_lsb[W-1-i]);
            chk("vec_vld", vld_m, 1);
         end
         tick();
         chk("vec_end_vld", vld_m, 0);
         chk("vec_end_dout", dout_m, 0);
      end

      // Back-to-back A5 then 3C with valid held high: 16 gapless bits.
      b2b        = 16'hA53C;
      data_valid = 1'b1;
      data_in    = 8'hA5;
      tick();
      data_in = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("b2b_bit", dout_m, b2b[15-i]);
         chk("b2b_vld", vld_m, 1);
         if (i == 1) chk("b2b_ready_low_while_held", rdy_m, 0);
         if (m_acc) data_valid = 1'b0;
      end
      tick();
      chk("b2b_end_vld", vld_m, 0);

      // Backpressure: three words, valid high for 20 cycles.
      bp_words[0] = 8'h11;
      bp_words[1] = 8'h5A;
      bp_words[2] = 8'hE7;
      wi          = 0;
      nacc        = 0;
      data_valid  = 1'b1;
      data_in     = bp_words[0];
      for (int c = 0; c < 32; c++) begin
         pre_rdy = rdy_m;
         tick();
         if (vld_m) got.push_back(dout_m);
         if (c < 20 && data_valid && pre_rdy) begin
            nacc++;
            wi++;
            if (wi < 3) data_in = bp_words[wi];
            else data_valid = 1'b0;
         end
      end
      chk("bp_accept_count", nacc, 3);
      chk("bp_bit_count", got.size(), 24);
      for (int i = 0; i < 24 && i < got.size(); i++)
         chk("bp_order", got[i], bp_words[i/8][7-(i%8)]);

      // Reset mid-word: FF shifting, 0F held.
      data_valid = 1'b1;
      data_in    = 8'hFF;
      tick();
      data_in = 8'h0F;
      tick();
      tick();
      data_valid = 1'b0;
      tick();
      chk("rst_pre_held", rdy_m, 0);
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_async_dout", dout_m, 0);
      chk("rst_async_vld", vld_m, 0);
      chk("rst_async_busy", busy_m, 0);
      chk("rst_async_ready", rdy_m, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rst_no_output", vld_m, 0);
      end

      // Starvation gap: 80, three idle cycles, then 01.
      starve_w   = 8'h80;
      data_valid = 1'b1;
      data_in    = starve_w;
      tick();
      data_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         tick();
         chk("starve_w0_bit", dout_m, starve_w[W-1-i]);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("starve_gap_vld", vld_m, 0);
         chk("starve_gap_dout", dout_m, 0);
      end
      data_valid = 1'b1;
      data_in    = 8'h01;
      tick();
      chk("starve_accept_vld", vld_m, 0);
      data_valid = 1'b0;
      tick();
      chk("starve_first_vld", vld_m, 1);
      chk("starve_first_msb", dout_m, 0);
      chk("starve_first_lsb", dout_l, 1);
      for (int i = 0; i < W; i++) tick();

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         tick();
         if (m_acc) data_valid = 1'b0;
         if (!data_valid && $urandom_range(0, 9) < 6) begin
            data_valid = 1'b1;
            data_in    = W'($urandom);
         end
      end
      data_valid = 1'b0;
      for (int i = 0; i < 2 * W + 2; i++) tick();
      chk("final_idle_busy", busy_m, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
